snurisc_icache: RTL

Direct-mapped, read-only instruction cache sitting directly upstream of the frontend fetch stage. It accepts word fetch requests from the frontend, returns the instruction in one cycle on a hit, and on a miss refills a whole line from the memory side. The core owns flush for fence.i and reset recovery.

---
 rtl/snurisc_icache_if.sv | 29 ++
 rtl/snurisc_icache.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/snurisc_icache_if.sv
// Fetch-side and memory-side signal bundle for the snurisc instruction cache.
// The slave modport is the cache's view; the master modport is the view of
// whatever drives it (core fetch stage plus memory responder).
interface snurisc_icache_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              i_rq;
    logic [AWIDTH-1:0] i_addr;
    logic              o_ready;
    logic              o_valid;
    logic [DWIDTH-1:0] o_inst;
    logic              i_flush;
    logic              o_mem_rq;
    logic [AWIDTH-1:0] o_mem_addr;
    logic              i_mem_ack;
    logic              i_mem_rvalid;
    logic [DWIDTH-1:0] i_mem_rdata;

    modport slave (
        input  i_rq, i_addr, i_flush, i_mem_ack, i_mem_rvalid, i_mem_rdata,
        output o_ready, o_valid, o_inst, o_mem_rq, o_mem_addr
    );

    modport master (
        output i_rq, i_addr, i_flush, i_mem_ack, i_mem_rvalid, i_mem_rdata,
        input  o_ready, o_valid, o_inst, o_mem_rq, o_mem_addr
    );
endinterface

// File: rtl/snurisc_icache.sv
// Direct-mapped read-only instruction cache. Hits answer one cycle after the
// request is accepted; misses fetch a whole line (word 0 first) and then
// replay the lookup. A flush during a refill lets the memory transaction run
// to completion but leaves the line invalid.
module snurisc_icache #(
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
) (
    input  logic           i_clk,
    input  logic           i_reset,
    snurisc_icache_if.slave bus
);
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = AWIDTH - OFF_W - IDX_W;
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMPARE  = 2'd1,
        ST_MISS_REQ = 2'd2,
        ST_REFILL   = 2'd3
    } state_t;

    state_t              state_q;
    logic [AWIDTH-3:0]   waddr_q;       // word address of the accepted request
    logic [WORD_W-1:0]   cnt_q;         // refill beat counter
    logic                flush_pend_q;  // flush seen while a refill is in flight
    logic [DWIDTH-1:0]   inst_q;        // last delivered instruction
    logic [NUM_LINES-1:0] valid_q;

    logic [TAG_W-1:0]    tag_mem  [NUM_LINES];
    logic [DWIDTH-1:0]   data_mem [NUM_LINES][LINE_WORDS];

    logic [IDX_W-1:0]    idx_s;
    logic [TAG_W-1:0]    tag_s;
    logic [WORD_W-1:0]   word_s;
    logic [AWIDTH-1:0]   line_addr_s;
    logic                hit_s;
    logic                beat_s;
    logic                last_beat_s;
    logic                accept_s;
    logic                ready_s;
    logic                valid_s;
    logic [DWIDTH-1:0]   inst_s;
    logic                mem_rq_s;
    logic [AWIDTH-1:0]   mem_addr_s;

    assign word_s      = waddr_q[WORD_W-1:0];
    assign idx_s       = waddr_q[WORD_W +: IDX_W];
    assign tag_s       = waddr_q[AWIDTH-3 -: TAG_W];
    assign line_addr_s = {waddr_q[AWIDTH-3:WORD_W], {OFF_W{1'b0}}};
    assign hit_s       = valid_q[idx_s] && (tag_mem[idx_s] == tag_s);
    assign beat_s      = (state_q == ST_REFILL) && bus.i_mem_rvalid;
    assign last_beat_s = beat_s && (cnt_q == LAST_BEAT);
    assign accept_s    = bus.i_rq && ready_s;

    // Output decode from the current state; reset and flush force outputs quiet.
    always_comb begin
        ready_s    = 1'b0;
        valid_s    = 1'b0;
        inst_s     = inst_q;
        mem_rq_s   = 1'b0;
        mem_addr_s = '0;
        if (i_reset) begin
            inst_s = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_s = !bus.i_flush;
                end
                ST_COMPARE: begin
                    if (hit_s && !bus.i_flush) begin
                        ready_s = 1'b1;
                        valid_s = 1'b1;
                        inst_s  = data_mem[idx_s][word_s];
                    end else begin
                        ready_s = 1'b0;
                        valid_s = 1'b0;
                    end
                end
                ST_MISS_REQ: begin
                    mem_rq_s   = 1'b1;
                    mem_addr_s = line_addr_s;
                end
                ST_REFILL: begin
                    ready_s = 1'b0;
                end
                default: begin
                    ready_s = 1'b0;
                end
            endcase
        end
    end

    assign bus.o_ready    = ready_s;
    assign bus.o_valid    = valid_s;
    assign bus.o_inst     = inst_s;
    assign bus.o_mem_rq   = mem_rq_s;
    assign bus.o_mem_addr = mem_addr_s;

    // Control FSM: lookup, miss request, refill, valid bits and flush tracking.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            waddr_q      <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            inst_q       <= '0;
            valid_q      <= '0;
        end else begin
            if (accept_s) begin
                waddr_q <= bus.i_addr[AWIDTH-1:2];
            end
            if (valid_s) begin
                inst_q <= inst_s;
            end
            case (state_q)
                ST_IDLE: begin
                    state_q <= accept_s ? ST_COMPARE : ST_IDLE;
                end
                ST_COMPARE: begin
                    if (bus.i_flush) begin
                        state_q <= ST_IDLE;
                    end else if (hit_s) begin
                        state_q <= accept_s ? ST_COMPARE : ST_IDLE;
                    end else begin
                        state_q <= ST_MISS_REQ;
                    end
                end
                ST_MISS_REQ: begin
                    if (bus.i_flush) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (bus.i_mem_ack) begin
                        state_q <= ST_REFILL;
                        cnt_q   <= '0;
                    end
                end
                ST_REFILL: begin
                    if (beat_s) begin
                        cnt_q <= cnt_q + WORD_W'(1);
                    end
                    if (last_beat_s) begin
                        flush_pend_q <= 1'b0;
                        if (flush_pend_q || bus.i_flush) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q        <= ST_COMPARE;
                            valid_q[idx_s] <= 1'b1;
                        end
                    end else if (bus.i_flush) begin
                        flush_pend_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
            if (bus.i_flush) begin
                valid_q <= '0;
            end
        end
    end

    // Line storage: refill beats fill data words, the last beat writes the tag.
    always_ff @(posedge i_clk) begin
        if (!i_reset && beat_s) begin
            data_mem[idx_s][cnt_q] <= bus.i_mem_rdata;
        end
        if (!i_reset && last_beat_s) begin
            tag_mem[idx_s] <= tag_s;
        end
    end
endmodule
